// File: rtl/fc_pkg.sv
// Shared types and constants for the fully connected layer controller.
package fc_pkg;

    localparam int unsigned WORD_SIZE_DEF = 16;
    localparam int unsigned INT_SLICE_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } fc_state_t;

    function automatic int unsigned dec_slice(input int unsigned word_size,
                                              input int unsigned int_slice);
        return word_size - int_slice;
    endfunction

endpackage

// File: rtl/fc_fixed_mul.sv
// Signed fixed-point multiply, result truncated toward zero to one word.
module fc_fixed_mul
    import fc_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
    parameter int unsigned INT_SLICE = INT_SLICE_DEF
) (
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic [WORD_SIZE-1:0] y
);

    localparam int unsigned DEC = dec_slice(WORD_SIZE, INT_SLICE);
    localparam int unsigned PW  = 2 * WORD_SIZE;

    logic signed [PW-1:0]        a_ext;
    logic signed [PW-1:0]        b_ext;
    logic signed [PW-1:0]        p;
    logic        [PW-1:0]        mag;
    logic        [WORD_SIZE-1:0] slice;

    // Slicing the magnitude (not P itself) makes negative results round toward zero.
    always_comb begin
        a_ext = PW'($signed(a));
        b_ext = PW'($signed(b));
        p     = a_ext * b_ext;
        mag   = p[PW-1] ? PW'(-p) : PW'(p);
        slice = mag[DEC+WORD_SIZE-1:DEC];
        y     = p[PW-1] ? WORD_SIZE'(-slice) : slice;
    end

endmodule

// File: rtl/fc_controller.sv
// Sequences one MAC unit over a fully connected layer: Z[i] = B[i] + sum_j X[j]*W[i][j].
module fc_controller
    import fc_pkg::*;
#(
    parameter int unsigned WORD_SIZE     = WORD_SIZE_DEF,
    parameter int unsigned INT_SLICE     = INT_SLICE_DEF,
    parameter int unsigned IP_LAYER_SIZE = 128,
    parameter int unsigned OP_LAYER_SIZE = 84,
    localparam int unsigned XW = (IP_LAYER_SIZE > 1) ? $clog2(IP_LAYER_SIZE) : 1,
    localparam int unsigned BW = (OP_LAYER_SIZE > 1) ? $clog2(OP_LAYER_SIZE) : 1,
    localparam int unsigned WW = (OP_LAYER_SIZE * IP_LAYER_SIZE > 1) ?
                                 $clog2(OP_LAYER_SIZE * IP_LAYER_SIZE) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [XW-1:0]        x_addr,
    input  logic [WORD_SIZE-1:0] x_rdata,
    output logic [WW-1:0]        w_addr,
    input  logic [WORD_SIZE-1:0] w_rdata,
    output logic [BW-1:0]        b_addr,
    input  logic [WORD_SIZE-1:0] b_rdata,
    output logic                 z_we,
    output logic [BW-1:0]        z_addr,
    output logic [WORD_SIZE-1:0] z_wdata
);

    localparam logic [XW-1:0] J_LAST = XW'(IP_LAYER_SIZE - 1);
    localparam logic [BW-1:0] I_LAST = BW'(OP_LAYER_SIZE - 1);
    localparam logic [WW-1:0] ROW    = WW'(IP_LAYER_SIZE);

    fc_state_t            state;
    logic [BW-1:0]        i;
    logic [XW-1:0]        j;
    logic [WORD_SIZE-1:0] acc;
    logic [WORD_SIZE-1:0] prod;
    logic [WORD_SIZE-1:0] acc_sum;

    fc_fixed_mul #(
        .WORD_SIZE(WORD_SIZE),
        .INT_SLICE(INT_SLICE)
    ) u_mul (
        .a(x_rdata),
        .b(w_rdata),
        .y(prod)
    );

    assign acc_sum = acc + prod;

    // Addresses are registered one state ahead so the RAM sees them for the whole cycle;
    // read data then lines up with the following state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            i       <= '0;
            j       <= '0;
            acc     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            z_we    <= 1'b0;
            x_addr  <= '0;
            w_addr  <= '0;
            b_addr  <= '0;
            z_addr  <= '0;
            z_wdata <= '0;
        end else begin
            done <= 1'b0;
            z_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= BIAS;
                        i      <= '0;
                        b_addr <= '0;
                        busy   <= 1'b1;
                    end
                end
                BIAS: begin
                    state  <= MAC;
                    j      <= '0;
                    x_addr <= '0;
                    w_addr <= WW'(i) * ROW;
                end
                MAC: begin
                    if (j == '0) begin
                        acc <= b_rdata;
                    end else begin
                        acc <= acc_sum;
                    end
                    if (j == J_LAST) begin
                        state <= DRAIN;
                    end else begin
                        j      <= j + 1'b1;
                        x_addr <= j + 1'b1;
                        w_addr <= w_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    acc     <= acc_sum;
                    state   <= WRITE;
                    z_we    <= 1'b1;
                    z_addr  <= i;
                    z_wdata <= acc_sum;
                end
                WRITE: begin
                    if (i == I_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        i      <= i + 1'b1;
                        b_addr <= i + 1'b1;
                        state  <= BIAS;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_controller.sv
// Directed bench for fc_controller: two instances (2x2 and 3x2) checked against a cycle model.
module tb_fc_controller;

    localparam int IPA = 2;
    localparam int OPA = 2;
    localparam int IPB = 3;
    localparam int OPB = 2;

    typedef struct {
        bit busy;
        bit done;
        bit we;
        bit mac;
        bit bias;
        int n;
        int x;
        int w;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: IP=2, OP=2
    logic        busy_a, done_a, z_we_a;
    logic [0:0]  xa_addr, ba_addr, za_addr;
    logic [1:0]  wa_addr;
    logic [15:0] xa_rdata, wa_rdata, ba_rdata, za_wdata;
    logic [15:0] xa_mem[0:1];
    logic [15:0] wa_mem[0:3];
    logic [15:0] ba_mem[0:1];

    // Instance B: IP=3, OP=2
    logic        busy_b, done_b, z_we_b;
    logic [1:0]  xb_addr;
    logic [0:0]  bb_addr, zb_addr;
    logic [2:0]  wb_addr;
    logic [15:0] xb_rdata, wb_rdata, bb_rdata, zb_wdata;
    logic [15:0] xb_mem[0:2];
    logic [15:0] wb_mem[0:5];
    logic [15:0] bb_mem[0:1];

    fc_controller #(.WORD_SIZE(16), .INT_SLICE(8), .IP_LAYER_SIZE(IPA), .OP_LAYER_SIZE(OPA)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .x_addr(xa_addr), .x_rdata(xa_rdata), .w_addr(wa_addr), .w_rdata(wa_rdata),
        .b_addr(ba_addr), .b_rdata(ba_rdata), .z_we(z_we_a), .z_addr(za_addr), .z_wdata(za_wdata)
    );

    fc_controller #(.WORD_SIZE(16), .INT_SLICE(8), .IP_LAYER_SIZE(IPB), .OP_LAYER_SIZE(OPB)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .x_addr(xb_addr), .x_rdata(xb_rdata), .w_addr(wb_addr), .w_rdata(wb_rdata),
        .b_addr(bb_addr), .b_rdata(bb_rdata), .z_we(z_we_b), .z_addr(zb_addr), .z_wdata(zb_wdata)
    );

    always @(posedge clk) begin
        xa_rdata <= xa_mem[xa_addr];
        wa_rdata <= wa_mem[wa_addr];
        ba_rdata <= ba_mem[ba_addr];
        xb_rdata <= xb_mem[xb_addr];
        wb_rdata <= wb_mem[wb_addr];
        bb_rdata <= bb_mem[bb_addr];
    end

    // Model: a pass is just a cycle offset from the accepting edge.
    bit act_a, act_b;
    int off_a, off_b;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            act_a <= 1'b0; off_a <= 0; act_b <= 1'b0; off_b <= 0;
        end else begin
            if (!act_a) begin
                if (start_a) begin act_a <= 1'b1; off_a <= 0; end
            end else if (off_a == OPA * (IPA + 3)) act_a <= 1'b0;
            else off_a <= off_a + 1;
            if (!act_b) begin
                if (start_b) begin act_b <= 1'b1; off_b <= 0; end
            end else if (off_b == OPB * (IPB + 3)) act_b <= 1'b0;
            else off_b <= off_b + 1;
        end
    end

    task automatic check(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic int prod(input logic [15:0] x, input logic [15:0] w);
        longint p;
        p = longint'($signed(x)) * longint'($signed(w));
        p = p / 256;  // integer division truncates toward zero
        return int'(p[15:0]);
    endfunction

    function automatic int z_model(input bit inst, input int n);
        int acc;
        int ip;
        ip  = inst ? IPB : IPA;
        acc = inst ? int'(bb_mem[n]) : int'(ba_mem[n]);
        for (int k = 0; k < ip; k++) begin
            if (inst) acc = (acc + prod(xb_mem[k], wb_mem[n*ip+k])) & 32'hFFFF;
            else      acc = (acc + prod(xa_mem[k], wa_mem[n*ip+k])) & 32'hFFFF;
        end
        return acc;
    endfunction

    function automatic exp_t expect_at(input int ip, input int op, input bit act, input int off);
        exp_t e;
        int per, r;
        e = '{default: 0};
        per = ip + 3;
        if (act) begin
            e.busy = 1'b1;
            e.n = off / per;
            r = off % per;
            if (off == op * per) e.done = 1'b1;
            else if (r == 0) e.bias = 1'b1;
            else if (r <= ip) begin
                e.mac = 1'b1;
                e.x = r - 1;
                e.w = e.n * ip + r - 1;
            end else if (r == ip + 2) e.we = 1'b1;
        end
        return e;
    endfunction

    task automatic cmp(input string p, input exp_t e, input logic busy, input logic done,
                       input logic we, input int x, input int w, input int b, input int za,
                       input int zd, input int zexp);
        check({p, "_busy"}, int'(busy), int'(e.busy));
        check({p, "_done"}, int'(done), int'(e.done));
        check({p, "_z_we"}, int'(we), int'(e.we));
        if (e.bias) check({p, "_b_addr"}, b, e.n);
        if (e.mac) begin
            check({p, "_x_addr"}, x, e.x);
            check({p, "_w_addr"}, w, e.w);
        end
        if (e.we) begin
            check({p, "_z_addr"}, za, e.n);
            check({p, "_z_wdata"}, zd, zexp);
        end
    endtask

    int qa[$];
    int qb[$];
    int qb_addr[$];
    int wseq[$];
    int xseq[$];
    int bseq[$];
    int done_cnt_a = 0;

    always @(negedge clk) begin
        exp_t ea, eb;
        if (rst) begin
            check("rst_outs_a", int'({busy_a, done_a, z_we_a, xa_addr, wa_addr, ba_addr,
                                      za_addr}), 0);
            check("rst_zd_a", int'(za_wdata), 0);
            check("rst_outs_b", int'({busy_b, done_b, z_we_b, xb_addr, wb_addr, bb_addr,
                                      zb_addr}), 0);
            check("rst_zd_b", int'(zb_wdata), 0);
        end else begin
            ea = expect_at(IPA, OPA, act_a, off_a);
            eb = expect_at(IPB, OPB, act_b, off_b);
            cmp("a", ea, busy_a, done_a, z_we_a, int'(xa_addr), int'(wa_addr), int'(ba_addr),
                int'(za_addr), int'(za_wdata), ea.we ? z_model(1'b0, ea.n) : 0);
            cmp("b", eb, busy_b, done_b, z_we_b, int'(xb_addr), int'(wb_addr), int'(bb_addr),
                int'(zb_addr), int'(zb_wdata), eb.we ? z_model(1'b1, eb.n) : 0);
            if (z_we_a) qa.push_back(int'(za_wdata));
            if (done_a) done_cnt_a++;
            if (z_we_b) begin
                qb.push_back(int'(zb_wdata));
                qb_addr.push_back(int'(zb_addr));
            end
            if (eb.mac) begin
                wseq.push_back(int'(wb_addr));
                xseq.push_back(int'(xb_addr));
            end
            if (eb.bias) bseq.push_back(int'(bb_addr));
        end
    end

    task automatic wait_done(input bit inst, input int budget, output int c);
        c = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if ((inst ? done_b : done_a) === 1'b1) begin
                c = cyc;
                break;
            end
        end
        check(inst ? "b_done_seen" : "a_done_seen", int'(c >= 0), 1);
    endtask

    task automatic kick(input bit inst, output int c0);
        if (inst) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        c0 = cyc;
        if (inst) start_b = 1'b0; else start_a = 1'b0;
    endtask

    initial begin
        int c0, cd, found;
        xa_mem = '{16'h0100, 16'h0200};
        wa_mem = '{16'h0080, 16'h0040, 16'h0100, 16'hFF00};
        ba_mem = '{16'h0100, 16'h0000};
        xb_mem = '{16'h0100, 16'h0200, 16'h0300};
        wb_mem = '{16'h0100, 16'h0100, 16'h0100, 16'h0080, 16'h0080, 16'h0080};
        bb_mem = '{16'h0000, 16'h0010};
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("mdl_a_z0", z_model(1'b0, 0), 32'h0200);
        check("mdl_a_z1", z_model(1'b0, 1), 32'hFF00);
        check("mdl_b_z0", z_model(1'b1, 0), 32'h0600);
        check("mdl_b_z1", z_model(1'b1, 1), 32'h0310);

        // Pass 1 with a start glitch while busy
        qa.delete();
        done_cnt_a = 0;
        kick(1'b0, c0);
        repeat (3) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0, 100, cd);
        check("a_done_latency", cd - c0, 10);
        check("a_writes", qa.size(), 2);
        if (qa.size() == 2) begin
            check("a_z0", qa[0], 32'h0200);
            check("a_z1", qa[1], 32'hFF00);
        end
        repeat (4) @(negedge clk);
        check("a_done_count", done_cnt_a, 1);
        check("a_idle_busy", int'(busy_a), 0);

        // Negative truncation toward zero
        xa_mem = '{16'hFF80, 16'hFE00};
        wa_mem = '{16'h0001, 16'h0000, 16'h0000, 16'h0180};
        ba_mem = '{16'h0000, 16'h0000};
        check("mdl_neg_z1", z_model(1'b0, 1), 32'hFD00);
        qa.delete();
        kick(1'b0, c0);
        wait_done(1'b0, 100, cd);
        check("neg_writes", qa.size(), 2);
        if (qa.size() == 2) begin
            check("neg_z0", qa[0], 32'h0000);
            check("neg_z1", qa[1], 32'hFD00);
        end
        @(negedge clk);

        // Wrap, with start held high across two passes
        xa_mem = '{16'h0100, 16'h0100};
        wa_mem = '{16'h0100, 16'h0100, 16'h0000, 16'h0000};
        ba_mem = '{16'h7F00, 16'h1234};
        qa.delete();
        start_a = 1'b1;
        wait_done(1'b0, 100, cd);
        @(negedge clk);
        check("held_idle_gap", int'(busy_a), 0);
        @(negedge clk);
        check("held_restart_busy", int'(busy_a), 1);
        check("held_restart_baddr", int'(ba_addr), 0);
        start_a = 1'b0;
        wait_done(1'b0, 100, cd);
        check("wrap_writes", qa.size(), 4);
        if (qa.size() == 4) begin
            check("wrap_z0", qa[0], 32'h8100);
            check("wrap_z1", qa[1], 32'h1234);
            check("wrap_z0_again", qa[2], 32'h8100);
        end
        @(negedge clk);

        // Address sequencing on the 3x2 instance
        qb.delete(); qb_addr.delete(); wseq.delete(); xseq.delete(); bseq.delete();
        kick(1'b1, c0);
        wait_done(1'b1, 100, cd);
        check("b_done_latency", cd - c0, OPB * (IPB + 3));
        check("b_mac_cycles", wseq.size(), 6);
        for (int k = 0; k < wseq.size() && k < 6; k++) begin
            check("b_wseq", wseq[k], k);
            check("b_xseq", xseq[k], k % 3);
        end
        check("b_bias_cycles", bseq.size(), 2);
        if (bseq.size() == 2) begin
            check("b_bseq0", bseq[0], 0);
            check("b_bseq1", bseq[1], 1);
        end
        check("b_writes", qb.size(), 2);
        if (qb.size() == 2) begin
            check("b_zaddr0", qb_addr[0], 0);
            check("b_zaddr1", qb_addr[1], 1);
            check("b_z0", qb[0], 32'h0600);
            check("b_z1", qb[1], 32'h0310);
        end
        @(negedge clk);

        // Asynchronous reset in MAC, neuron 1, j=1
        kick(1'b1, c0);
        found = 0;
        for (int k = 0; k < 50; k++) begin
            if (act_b && off_b == IPB + 3 + 2) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("rst_point_found", found, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", int'(busy_b), 0);
        check("async_rst_addrs", int'({xb_addr, wb_addr, bb_addr, zb_addr}), 0);
        check("async_rst_we_done", int'({z_we_b, done_b}), 0);
        check("async_rst_zdata", int'(zb_wdata), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        qb.delete();
        repeat (12) @(negedge clk);
        check("post_rst_no_write", qb.size(), 0);
        check("post_rst_idle", int'(busy_b), 0);
        kick(1'b1, c0);
        wait_done(1'b1, 100, cd);
        check("post_rst_writes", qb.size(), 2);
        if (qb.size() == 2) begin
            check("post_rst_z0", qb[0], 32'h0600);
            check("post_rst_z1", qb[1], 32'h0310);
        end
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
